alu_seq_core: RTL and testbench
===============================

Name: alu_seq_core

Overview:
- Parametrised, handshaked successor to the CPU ALU datapath. Data width is configurable.
- Single-cycle ops (add/sub/logic/shift/compare) retire in one cycle. DIV/MOD use an iterative restoring divider, so one unit can replace the combinational divider.
- Sits between the instruction decoder (operand/opcode issue) and the register-file/status-register writeback.
- Results are held until the consumer accepts them.

Parameters:
- W, 32, operand/result width (>=8).
- SH_W, $clog2(W), shift-amount field width taken from b_i.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  opcode/operands valid.
- in_ready  out  1  core can accept an op.
- op_i  in  5  opcode.
- a_i  in  W  operand A.
- b_i  in  W  operand B (or immediate, zero-extended by the decoder).
- carry_i  in  1  current SR carry, used by ADDC/SUBC.
- sgn_i  in  1  signed mode for CP/DIV/MOD/ASR semantics.
- out_valid  out  1  result/status valid.
- out_ready  in  1  consumer accepts the result.
- result_o  out  W  result.
- status_o  out  8  flags: [7]C [6]N [5]DZ [4]ILL [3:2]0 [1:0]CPI.
- busy_o  out  1  multi-cycle op in progress.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=0 while in reset, 1 on the first cycle after release; out_valid=0; busy_o=0; result_o=0; status_o=0; divider counters cleared.
- A reset mid-operation aborts the op with no output.
- States: IDLE, EXEC, HOLD.
  - in_ready=1 only in IDLE.
  - Accept = in_valid & in_ready. Operands, op and carry_i are latched on accept.
- Single-cycle ops: accept at edge t -> HOLD, with out_valid=1 after edge t (latency 1).
- DIV/MOD: accept -> EXEC, busy_o=1, W iterations (one quotient bit per cycle, MSB first) -> HOLD.
  - out_valid rises W+1 cycles after accept.
- HOLD: result_o and status_o stay stable while out_valid=1 and out_ready=0. On out_valid & out_ready -> IDLE, out_valid=0.
  - No back-to-back accept in the same cycle as a handshake: minimum spacing is 2 cycles.
- Opcodes:
  - 0 ADD: {C,res}=A+B.
  - 1 ADDC: {C,res}=A+B+carry.
  - 2 SUB: res=A-B, C=borrow (A<B unsigned).
  - 3 SUBC: res=A-B-carry, C=borrow.
  - 4 MUL: res=low W of A*B; C=1 if the high W bits are nonzero.
  - 5 DIV: res=A/B.
  - 6 MOD: res=A%B.
  - 7 SHL: res=A<<b[SH_W-1:0].
  - 8 SHR: logical right shift.
  - 9 ASR: arithmetic right shift.
  - 10 AND. 11 OR. 12 XOR.
  - 13 CP: res=0; CPI=11 if eq, 10 if A>B, 01 if A<B. Comparison is signed when sgn_i=1.
  - 14 PASS: res=A.
  - 15-31: illegal; res=0, ILL=1, latency 1.
- Shifts: only b[SH_W-1:0] is used; if any higher bit of b is set, res=0 for SHL/SHR and all-sign-bits for ASR. C=last bit shifted out (0 for a zero shift amount).
- Flags:
  - N=res[W-1] for every op except CP.
  - C=0 for ops not listed above.
  - DZ and ILL are 0 unless set by their op.
  - CPI is 00 for all ops except CP.
- Signed DIV/MOD (sgn_i=1): operate on magnitudes, then negate. The quotient is negative iff the operand signs differ; the remainder takes the dividend's sign.
  - Most-negative / -1: quotient=most-negative, remainder=0.
- Divide by zero (B=0): no EXEC, latency 1; DIV res=all ones, MOD res=A; DZ=1.

Optional Feature:
- ALU_SEQ_MUL_ITER_EN.
  - Defined: MUL goes through EXEC as a W-cycle shift-add multiplier. out_valid rises W+1 cycles after accept and busy_o=1 during EXEC. Results and flags are identical to the combinational version.
  - Undefined: MUL is single-cycle combinational, latency 1.

Test Plan:
- Reset release then ADD A=0xFFFFFFFF, B=1 (W=32) -> out_valid next cycle, result 0x00000000, status C=1, N=0.
- SUBC A=5, B=5, carry_i=1 -> result 0xFFFFFFFF, C=1, N=1. Hold out_ready=0 for 3 cycles -> outputs stable, in_ready=0 throughout.
- DIV sgn_i=1, A=-7, B=2 -> busy_o for 32 cycles, out_valid at accept+33, result -3. Then MOD, same operands -> result -1.
- DIV B=0, A=9 -> latency 1, result 0xFFFFFFFF, DZ=1. MOD B=0 -> result 9, DZ=1.
- CP A=0x80000000, B=1: sgn_i=1 -> CPI=01; sgn_i=0 -> CPI=10. ASR A=0x80000000, b=40 -> result 0xFFFFFFFF. Opcode 20 -> result 0, ILL=1.
- Assert rst_n=0 during DIV EXEC cycle 10 -> out_valid, busy_o and result_o read 0 while in reset. After release, in_ready=1 and no stale result appears.

Source files
------------

// File: rtl/alu_seq_core.sv
// Handshaked ALU: single-cycle ops plus an iterative restoring divider for DIV/MOD.
// Define ALU_SEQ_MUL_ITER_EN to route MUL through a W-cycle shift-add multiplier.
module alu_seq_core #(
  parameter int unsigned W    = 32,
  parameter int unsigned SH_W = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [4:0]   op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         carry_i,
  input  logic         sgn_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result_o,
  output logic [7:0]   status_o,
  output logic         busy_o
);

  localparam int unsigned CW = $clog2(W + 1);

  localparam logic [4:0] OP_ADD  = 5'd0,  OP_ADDC = 5'd1,  OP_SUB  = 5'd2,  OP_SUBC = 5'd3;
  localparam logic [4:0] OP_MUL  = 5'd4,  OP_DIV  = 5'd5,  OP_MOD  = 5'd6,  OP_SHL  = 5'd7;
  localparam logic [4:0] OP_SHR  = 5'd8,  OP_ASR  = 5'd9,  OP_AND  = 5'd10, OP_OR   = 5'd11;
  localparam logic [4:0] OP_XOR  = 5'd12, OP_CP   = 5'd13, OP_PASS = 5'd14;

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t         state;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   rem_q, dq_q, dv_q;
  logic [4:0]     op_q;
  logic           neg_q, neg_r;
`ifdef ALU_SEQ_MUL_ITER_EN
  logic [2*W-1:0] acc_q, mc_q, acc_nx_c;
`else
  logic [2*W-1:0] prod_c;
`endif

  logic [W-1:0]   res_c, a_mag_c, b_mag_c;
  logic           c_c, dz_c, ill_c, multi_c, sh_ovf_c, gt_c;
  logic [1:0]     cpi_c;
  logic [W:0]     wide_c;
  logic [SH_W-1:0] sh_c;

  // Single-cycle datapath, evaluated on the issue-cycle operands
  always_comb begin
    res_c    = '0;
    c_c      = 1'b0;
    dz_c     = 1'b0;
    ill_c    = 1'b0;
    multi_c  = 1'b0;
    cpi_c    = 2'b00;
    wide_c   = '0;
`ifndef ALU_SEQ_MUL_ITER_EN
    prod_c   = '0;
`endif
    sh_c     = b_i[SH_W-1:0];
    sh_ovf_c = (|(b_i >> SH_W)) || (W'(sh_c) >= W'(W));
    gt_c     = sgn_i ? ($signed(a_i) > $signed(b_i)) : (a_i > b_i);
    a_mag_c  = (sgn_i && a_i[W-1]) ? -a_i : a_i;
    b_mag_c  = (sgn_i && b_i[W-1]) ? -b_i : b_i;
    case (op_i)
      OP_ADD:  begin wide_c = {1'b0, a_i} + {1'b0, b_i}; {c_c, res_c} = wide_c; end
      OP_ADDC: begin wide_c = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, carry_i}; {c_c, res_c} = wide_c; end
      OP_SUB:  begin wide_c = {1'b0, a_i} - {1'b0, b_i}; {c_c, res_c} = wide_c; end
      OP_SUBC: begin wide_c = {1'b0, a_i} - {1'b0, b_i} - {{W{1'b0}}, carry_i}; {c_c, res_c} = wide_c; end
      OP_MUL: begin
`ifdef ALU_SEQ_MUL_ITER_EN
        multi_c = 1'b1;
`else
        prod_c = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};
        res_c  = prod_c[W-1:0];
        c_c    = |prod_c[2*W-1:W];
`endif
      end
      OP_DIV, OP_MOD: begin
        if (b_i == '0) begin
          dz_c  = 1'b1;
          res_c = (op_i == OP_DIV) ? '1 : a_i;
        end else begin
          multi_c = 1'b1;
        end
      end
      // Extra low bit on the right-shift paths catches the last bit shifted out
      OP_SHL: begin
        wide_c = {1'b0, a_i} << sh_c;
        {c_c, res_c} = wide_c;
        if (sh_ovf_c) begin c_c = 1'b0; res_c = '0; end
      end
      OP_SHR: begin
        wide_c = {a_i, 1'b0} >> sh_c;
        {res_c, c_c} = wide_c;
        if (sh_ovf_c) begin c_c = 1'b0; res_c = '0; end
      end
      OP_ASR: begin
        wide_c = $signed({a_i, 1'b0}) >>> sh_c;
        {res_c, c_c} = wide_c;
        if (sh_ovf_c) begin c_c = a_i[W-1]; res_c = {W{a_i[W-1]}}; end
      end
      OP_AND:  res_c = a_i & b_i;
      OP_OR:   res_c = a_i | b_i;
      OP_XOR:  res_c = a_i ^ b_i;
      OP_CP:   cpi_c = (a_i == b_i) ? 2'b11 : (gt_c ? 2'b10 : 2'b01);
      OP_PASS: res_c = a_i;
      default: ill_c = 1'b1;
    endcase
  end

  logic [W:0]   trial_c;
  logic         ge_c, fin_c_c;
  logic [W-1:0] rem_nx_c, quo_nx_c, fin_res_c;

  // One restoring-divide step; the final step also applies the result signs
  always_comb begin
    trial_c  = {rem_q, dq_q[W-1]};
    ge_c     = trial_c >= {1'b0, dv_q};
    rem_nx_c = ge_c ? W'(trial_c - {1'b0, dv_q}) : W'(trial_c);
    quo_nx_c = {dq_q[W-2:0], ge_c};
    fin_res_c = (op_q == OP_DIV) ? (neg_q ? -quo_nx_c : quo_nx_c)
                                 : (neg_r ? -rem_nx_c : rem_nx_c);
    fin_c_c   = 1'b0;
`ifdef ALU_SEQ_MUL_ITER_EN
    acc_nx_c = dq_q[0] ? (acc_q + mc_q) : acc_q;
    if (op_q == OP_MUL) begin
      fin_res_c = acc_nx_c[W-1:0];
      fin_c_c   = |acc_nx_c[2*W-1:W];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy_o    <= 1'b0;
      result_o  <= '0;
      status_o  <= '0;
      cnt_q     <= '0;
      rem_q     <= '0;
      dq_q      <= '0;
      dv_q      <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
`ifdef ALU_SEQ_MUL_ITER_EN
      acc_q     <= '0;
      mc_q      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            op_q     <= op_i;
            if (multi_c) begin
              state <= EXEC;
              busy_o <= 1'b1;
              cnt_q <= '0;
              rem_q <= '0;
              dq_q  <= a_mag_c;
              dv_q  <= b_mag_c;
              neg_q <= sgn_i & (a_i[W-1] ^ b_i[W-1]);
              neg_r <= sgn_i & a_i[W-1];
`ifdef ALU_SEQ_MUL_ITER_EN
              acc_q <= '0;
              mc_q  <= {{W{1'b0}}, a_i};
              if (op_i == OP_MUL) dq_q <= b_i;
`endif
            end else begin
              state     <= HOLD;
              out_valid <= 1'b1;
              result_o  <= res_c;
              status_o  <= {c_c, res_c[W-1], dz_c, ill_c, 2'b00, cpi_c};
            end
          end
        end
        EXEC: begin
          cnt_q <= cnt_q + 1'b1;
`ifdef ALU_SEQ_MUL_ITER_EN
          if (op_q == OP_MUL) begin
            acc_q <= acc_nx_c;
            mc_q  <= mc_q << 1;
            dq_q  <= dq_q >> 1;
          end else begin
            rem_q <= rem_nx_c;
            dq_q  <= quo_nx_c;
          end
`else
          rem_q <= rem_nx_c;
          dq_q  <= quo_nx_c;
`endif
          if (cnt_q == CW'(W - 1)) begin
            state     <= HOLD;
            busy_o    <= 1'b0;
            out_valid <= 1'b1;
            result_o  <= fin_res_c;
            status_o  <= {fin_c_c, fin_res_c[W-1], 6'b000000};
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed + scoreboard bench for alu_seq_core (W=32).
module tb_alu_seq_core;
  localparam int unsigned W = 32;
`ifdef ALU_SEQ_MUL_ITER_EN
  localparam int MUL_LAT = W + 1, MUL_BUSY = W;
`else
  localparam int MUL_LAT = 1, MUL_BUSY = 0;
`endif

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         in_valid = 1'b0, in_ready, carry_i = 1'b0, sgn_i = 1'b0;
  logic [4:0]   op_i = '0;
  logic [W-1:0] a_i = '0, b_i = '0, result_o;
  logic         out_valid, out_ready = 1'b0, busy_o;
  logic [7:0]   status_o;

  alu_seq_core #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_i(op_i), .a_i(a_i), .b_i(b_i), .carry_i(carry_i), .sgn_i(sgn_i),
    .out_valid(out_valid), .out_ready(out_ready), .result_o(result_o),
    .status_o(status_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] res; logic [7:0] st; } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;

  function automatic logic [7:0] st(input logic c, n, dz, ill, input logic [1:0] cpi);
    return {c, n, dz, ill, 2'b00, cpi};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [W-1:0] a, b,
                       input logic c, s, input logic [W-1:0] er, input logic [7:0] es);
    int n = 0;
    while (!in_ready && n < 200) begin tick(); n++; end
    chk("in_ready_wait", 64'(in_ready), 64'd1);
    op_i = op; a_i = a; b_i = b; carry_i = c; sgn_i = s; in_valid = 1'b1;
    sb.push_back('{er, es});
    tick();
    in_valid = 1'b0;
  endtask

  // Waits for out_valid, checks latency/busy, holds for 'hold' cycles, then handshakes
  task automatic collect(input string tag, input int exp_lat, input int exp_busy, input int hold);
    int lat = 1, nb = 0;
    exp_t e;
    while (!out_valid && lat < 200) begin
      if (busy_o) nb++;
      tick(); lat++;
    end
    if (exp_lat > 0) chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    if (exp_busy >= 0) chk({tag, "_busy"}, 64'(nb), 64'(exp_busy));
    chk({tag, "_sb"}, 64'(sb.size()), 64'd1);
    e = sb.pop_front();
    chk({tag, "_res"}, 64'(result_o), 64'(e.res));
    chk({tag, "_st"}, 64'(status_o), 64'(e.st));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold_res"}, 64'(result_o), 64'(e.res));
      chk({tag, "_hold_st"}, 64'(status_o), 64'(e.st));
      chk({tag, "_hold_vld"}, 64'(out_valid), 64'd1);
      chk({tag, "_hold_rdy"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_drop"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [W:0]   rs;
    int           stale;

    repeat (3) tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_result", 64'(result_o), 64'd0);
    chk("rst_status", 64'(status_o), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    issue(5'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h0, st(1, 0, 0, 0, 2'b00));
    collect("add_wrap", 1, 0, 0);
    issue(5'd3, 32'd5, 32'd5, 1'b1, 1'b0, 32'hFFFF_FFFF, st(1, 1, 0, 0, 2'b00));
    collect("subc", 1, 0, 3);

    issue(5'd5, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 32'hFFFF_FFFD, st(0, 1, 0, 0, 2'b00));
    collect("sdiv", W + 1, W, 0);
    issue(5'd6, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 32'hFFFF_FFFF, st(0, 1, 0, 0, 2'b00));
    collect("smod", W + 1, W, 0);
    issue(5'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b1, 32'hFFFF_FFFD, st(0, 1, 0, 0, 2'b00));
    collect("sdiv_negb", W + 1, -1, 0);
    issue(5'd6, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b1, 32'd1, st(0, 0, 0, 0, 2'b00));
    collect("smod_negb", W + 1, -1, 0);
    issue(5'd5, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, st(0, 1, 0, 0, 2'b00));
    collect("sdiv_minneg", W + 1, -1, 0);
    issue(5'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0, st(0, 0, 0, 0, 2'b00));
    collect("smod_minneg", W + 1, -1, 0);

    issue(5'd5, 32'd9, 32'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, st(0, 1, 1, 0, 2'b00));
    collect("div_zero", 1, 0, 0);
    issue(5'd6, 32'd9, 32'd0, 1'b0, 1'b0, 32'd9, st(0, 0, 1, 0, 2'b00));
    collect("mod_zero", 1, 0, 0);

    issue(5'd13, 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h0, st(0, 0, 0, 0, 2'b01));
    collect("cp_signed", 1, 0, 0);
    issue(5'd13, 32'h8000_0000, 32'd1, 1'b0, 1'b0, 32'h0, st(0, 0, 0, 0, 2'b10));
    collect("cp_unsigned", 1, 0, 0);
    issue(5'd13, 32'h1234, 32'h1234, 1'b0, 1'b0, 32'h0, st(0, 0, 0, 0, 2'b11));
    collect("cp_eq", 1, 0, 0);
    issue(5'd9, 32'h8000_0000, 32'd40, 1'b0, 1'b0, 32'hFFFF_FFFF, st(1, 1, 0, 0, 2'b00));
    collect("asr_ovf", 1, 0, 0);
    issue(5'd9, 32'h0000_00F0, 32'd4, 1'b0, 1'b0, 32'h0000_000F, st(0, 0, 0, 0, 2'b00));
    collect("asr4", 1, 0, 0);
    issue(5'd7, 32'h8000_0001, 32'd1, 1'b0, 1'b0, 32'd2, st(1, 0, 0, 0, 2'b00));
    collect("shl1", 1, 0, 0);
    issue(5'd8, 32'd3, 32'd1, 1'b0, 1'b0, 32'd1, st(1, 0, 0, 0, 2'b00));
    collect("shr1", 1, 0, 0);
    issue(5'd20, 32'h55, 32'h66, 1'b0, 1'b0, 32'h0, st(0, 0, 0, 1, 2'b00));
    collect("illegal", 1, 0, 0);
    issue(5'd4, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 32'h0, st(1, 0, 0, 0, 2'b00));
    collect("mul_ovf", MUL_LAT, MUL_BUSY, 0);
    issue(5'd4, 32'd3, 32'd5, 1'b0, 1'b0, 32'd15, st(0, 0, 0, 0, 2'b00));
    collect("mul_small", MUL_LAT, MUL_BUSY, 0);
    issue(5'd1, 32'h7FFF_FFFF, 32'd0, 1'b1, 1'b0, 32'h8000_0000, st(0, 1, 0, 0, 2'b00));
    collect("addc", 1, 0, 0);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom; rb = W'($urandom_range(1, 5000));
      issue(5'd5, ra, rb, 1'b0, 1'b0, ra / rb, st(0, (ra / rb) >> (W - 1), 0, 0, 2'b00));
      collect("rdiv", W + 1, W, 0);
      issue(5'd6, ra, rb, 1'b0, 1'b0, ra % rb, st(0, 0, 0, 0, 2'b00));
      collect("rmod", W + 1, W, 0);
      rb = $urandom;
      rs = {1'b0, ra} + {1'b0, rb};
      issue(5'd0, ra, rb, 1'b0, 1'b0, rs[W-1:0], st(rs[W], rs[W-1], 0, 0, 2'b00));
      collect("radd", 1, 0, 0);
      issue(5'd12, ra, rb, 1'b0, 1'b0, ra ^ rb, st(0, ra[W-1] ^ rb[W-1], 0, 0, 2'b00));
      collect("rxor", 1, 0, 0);
    end

    // Reset in the middle of a divide must abort it with no output
    issue(5'd5, 32'd1000, 32'd7, 1'b0, 1'b0, 32'd142, st(0, 0, 0, 0, 2'b00));
    repeat (9) tick();
    chk("mid_busy_pre", 64'(busy_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy_o), 64'd0);
    chk("mid_rst_result", 64'(result_o), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rel_ready", 64'(in_ready), 64'd1);
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid || busy_o) stale++;
      tick();
    end
    chk("mid_no_stale", 64'(stale), 64'd0);

    issue(5'd14, 32'hCAFE_BABE, 32'd0, 1'b0, 1'b0, 32'hCAFE_BABE, st(0, 1, 0, 0, 2'b00));
    collect("pass_after_rst", 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
